load_return_unit: RTL

- Read-side counterpart to the execute stage's store path; the store path produces store_address/store_data/bwe.
- Accepts one load request per transaction from execute (byte address, funct3, rd) and issues a word-aligned read to dmem.
- Waits for the variable-latency response, then extracts, aligns and sign/zero-extends the addressed byte/half/word.
- Presents the result to writeback with a valid/ready handshake; at most one load is outstanding.

---
 rtl/load_return_unit_pkg.sv | 19 +
 rtl/load_return_unit_load_extract.sv | 40 ++++
 rtl/load_return_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/load_return_unit_pkg.sv
// Shared definitions for the load return path: RV32I load encodings,
// controller states and the word-align constant used on dmem_addr.
package load_return_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] WORD_ALIGN = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_HOLD = 2'b10
    } lru_state_e;

endpackage

// File: rtl/load_return_unit_load_extract.sv
// Combinational lane select and sign/zero extension of a little-endian read word;
// flags misaligned accesses and illegal funct3 (data forced to zero on error).
module load_extract
    import load_return_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        err
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        data   = '0;
        err    = 1'b0;
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:  data = {{24{lane_b[7]}}, lane_b};
            F3_LBU: data = {24'b0, lane_b};
            F3_LH: begin
                if (offset[0]) err = 1'b1;
                else           data = {{16{lane_h[15]}}, lane_h};
            end
            F3_LHU: begin
                if (offset[0]) err = 1'b1;
                else           data = {16'b0, lane_h};
            end
            F3_LW: begin
                if (offset != WORD_ALIGN) err = 1'b1;
                else                      data = word;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_return_unit.sv
// Single-outstanding load unit: issues a word-aligned dmem read, waits for the
// variable-latency response (with optional timeout), then holds the result for writeback.
module load_return_unit
    import load_return_unit_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    output logic        dmem_re,
    output logic [31:0] dmem_addr,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    lru_state_e       state;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             timed_out;
    logic [31:0]      ext_data;
    logic             ext_err;

    assign req_ready = (state == S_IDLE) || ((state == S_HOLD) && wb_ready);
    assign accept    = req_valid && req_ready;
    assign dmem_re   = accept;
    assign dmem_addr = {req_addr[31:2], WORD_ALIGN};
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

    load_extract u_extract (
        .word   (dmem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (ext_data),
        .err    (ext_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            off_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            cnt      <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_err   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // Accept only happens in IDLE or HOLD, so request capture never collides with WAIT counting.
            if (accept) begin
                off_q <= req_addr[1:0];
                f3_q  <= req_funct3;
                rd_q  <= req_rd;
                cnt   <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_WAIT;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (dmem_resp_valid) begin
                        state    <= S_HOLD;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= ext_data;
                        wb_err   <= ext_err;
                    end else if (timed_out) begin
                        state    <= S_HOLD;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= '0;
                        wb_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        if (accept) begin
                            state <= S_WAIT;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wb_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
